// File: rtl/branch_wb_unit.sv
// ============================================================================
// Module   : branch_wb_unit
// Brief    : Branch/jump resolution with fetch redirect and register writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_wb_unit #(
  parameter int XLEN     = 32,
  parameter int INSTR_W  = 37,
  parameter int BR_BASE  = 27,
  parameter int IALIGN   = 32,
  parameter int LINK_INC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_bus,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    rs1_value,
  input  logic [XLEN-1:0]    rs2_value,
  input  logic [XLEN-1:0]    imm,
  input  logic               rd_valid,
  input  logic [XLEN-1:0]    alu_result,
  input  logic               alu_ready,
  output logic [XLEN-1:0]    next_pc,
  output logic               pc_j_valid,
  output logic [XLEN-1:0]    rd_data,
  output logic               rd_write,
  output logic               misalign_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RESOLVE  = 2'd1,
    S_WAIT_ALU = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_br;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic            r_rd_valid;

  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_jalr_target;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_jump;
  logic            w_misalign;
  logic            w_eq;
  logic            w_slt;
  logic            w_ult;
  logic            w_unused_instr;

  // Only the branch slice of the one-hot bus matters here.
  assign w_unused_instr = ^instr_bus;

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  assign w_eq          = (r_rs1 == r_rs2);
  assign w_slt         = ($signed(r_rs1) < $signed(r_rs2));
  assign w_ult         = (r_rs1 < r_rs2);
  assign w_br_target   = r_pc + r_imm;
  assign w_jalr_target = (r_rs1 + r_imm) & ~XLEN'(1);

  // Priority chain: the first set bit whose condition holds selects the target.
  always_comb begin
    w_taken  = 1'b0;
    w_jump   = 1'b0;
    w_target = w_br_target;
    if (r_br[7]) begin
      w_taken  = 1'b1;
      w_jump   = 1'b1;
      w_target = w_jalr_target;
    end else if (r_br[6]) begin
      w_taken = 1'b1;
      w_jump  = 1'b1;
    end else if (r_br[5] && !w_ult) begin
      w_taken = 1'b1;
    end else if (r_br[4] && w_ult) begin
      w_taken = 1'b1;
    end else if (r_br[3] && !w_slt) begin
      w_taken = 1'b1;
    end else if (r_br[2] && w_slt) begin
      w_taken = 1'b1;
    end else if (r_br[1] && !w_eq) begin
      w_taken = 1'b1;
    end else if (r_br[0] && w_eq) begin
      w_taken = 1'b1;
    end
  end

  assign w_misalign = w_taken &&
                      ((IALIGN == 32) ? (w_target[1:0] != 2'b00) : w_target[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_br         <= '0;
      r_pc         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_imm        <= '0;
      r_rd_valid   <= 1'b0;
      next_pc      <= '0;
      rd_data      <= '0;
      pc_j_valid   <= 1'b0;
      rd_write     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      pc_j_valid   <= 1'b0;
      rd_write     <= 1'b0;
      misalign_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_br       <= instr_bus[BR_BASE+7:BR_BASE];
            r_pc       <= pc;
            r_rs1      <= rs1_value;
            r_rs2      <= rs2_value;
            r_imm      <= imm;
            r_rd_valid <= rd_valid;
            r_state    <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          r_state <= S_IDLE;
          if (w_misalign) begin
            misalign_err <= 1'b1;
          end else begin
            if (w_taken) begin
              next_pc    <= w_target;
              pc_j_valid <= 1'b1;
            end
            if (w_jump) begin
              if (r_rd_valid) begin
                rd_data  <= r_pc + XLEN'(LINK_INC);
                rd_write <= 1'b1;
              end
            end else if (r_rd_valid) begin
              if (alu_ready) begin
                rd_data  <= alu_result;
                rd_write <= 1'b1;
              end else begin
                r_state <= S_WAIT_ALU;
              end
            end
          end
        end
        S_WAIT_ALU: begin
          if (alu_ready) begin
            rd_data  <= alu_result;
            rd_write <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_wb_unit.sv
// ============================================================================
// Module   : tb_branch_wb_unit
// Brief    : Directed self-checking bench for branch_wb_unit (IALIGN 32 and 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_wb_unit;

  localparam int C_BEQ = 27, C_BNE = 28, C_BLT = 29, C_BGE = 30;
  localparam int C_BLTU = 31, C_BGEU = 32, C_JAL = 33, C_JALR = 34, C_ADD = 0;

  logic        clk, reset, in_valid, rd_valid, alu_ready;
  logic [36:0] instr_bus;
  logic [31:0] pc, rs1_value, rs2_value, imm, alu_result;

  logic        in_ready, pc_j_valid, rd_write, misalign_err, busy;
  logic [31:0] next_pc, rd_data;
  logic        in_ready16, pc_j_valid16, rd_write16, misalign_err16, busy16;
  logic [31:0] next_pc16, rd_data16;

  int checks = 0;
  int errors = 0;

  branch_wb_unit #(.IALIGN(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_bus(instr_bus), .pc(pc), .rs1_value(rs1_value), .rs2_value(rs2_value),
    .imm(imm), .rd_valid(rd_valid), .alu_result(alu_result), .alu_ready(alu_ready),
    .next_pc(next_pc), .pc_j_valid(pc_j_valid), .rd_data(rd_data), .rd_write(rd_write),
    .misalign_err(misalign_err), .busy(busy)
  );

  branch_wb_unit #(.IALIGN(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
    .instr_bus(instr_bus), .pc(pc), .rs1_value(rs1_value), .rs2_value(rs2_value),
    .imm(imm), .rd_valid(rd_valid), .alu_result(alu_result), .alu_ready(alu_ready),
    .next_pc(next_pc16), .pc_j_valid(pc_j_valid16), .rd_data(rd_data16),
    .rd_write(rd_write16), .misalign_err(misalign_err16), .busy(busy16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for a single accepting edge, checks the RESOLVE
  // cycle, and returns at the negedge just after the edge leaving RESOLVE.
  task automatic issue(input int b1, input int b2, input logic [31:0] a_pc,
                       input logic [31:0] a_rs1, input logic [31:0] a_rs2,
                       input logic [31:0] a_imm, input logic a_rdv);
    instr_bus = '0;
    if (b1 >= 0) instr_bus[b1] = 1'b1;
    if (b2 >= 0) instr_bus[b2] = 1'b1;
    pc = a_pc; rs1_value = a_rs1; rs2_value = a_rs2; imm = a_imm; rd_valid = a_rdv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr_bus = '0;
    pc = '0; rs1_value = '0; rs2_value = '0; imm = '0; rd_valid = 1'b0;
    @(negedge clk);
    chk("resolve_in_ready", in_ready, 0);
    chk("resolve_no_strobe", pc_j_valid | rd_write | misalign_err, 0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; rd_valid = 1'b0; alu_ready = 1'b0;
    instr_bus = '0; pc = '0; rs1_value = '0; rs2_value = '0; imm = '0; alu_result = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_strobes", {pc_j_valid, rd_write, misalign_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset while waiting for the ALU drops the pending writeback
    alu_result = 32'h1111_2222;
    issue(C_ADD, -1, 32'h10, 0, 0, 0, 1'b1);
    chk("wait_busy", busy, 1);
    chk("wait_no_wr", rd_write, 0);
    reset = 1'b1; alu_ready = 1'b1;
    @(negedge clk);
    chk("midrst_no_wr", rd_write, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_next_pc", next_pc, 0);
    reset = 1'b0; alu_ready = 1'b0;
    @(negedge clk);
    chk("midrst_after_wr", rd_write, 0);

    // Unsigned vs signed compare on the same operands
    issue(C_BLTU, -1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0);
    chk("bltu_no_jump", pc_j_valid, 0);
    chk("bltu_next_pc", next_pc, 0);
    issue(C_BLT, -1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0);
    chk("blt_jump", pc_j_valid, 1);
    chk("blt_next_pc", next_pc, 32'h120);
    @(negedge clk);
    chk("blt_pulse_end", pc_j_valid, 0);
    chk("blt_hold", next_pc, 32'h120);

    issue(C_BGEU, -1, 32'h500, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0);
    chk("bgeu_jump", pc_j_valid, 1);
    chk("bgeu_next_pc", next_pc, 32'h540);
    issue(C_BGE, -1, 32'h500, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0);
    chk("bge_no_jump", pc_j_valid, 0);
    chk("bge_hold", next_pc, 32'h540);

    // jalr clears bit 0 and links
    issue(C_JALR, -1, 32'h200, 32'h1001, 32'h0, 32'h4, 1'b1);
    chk("jalr_jump", pc_j_valid, 1);
    chk("jalr_next_pc", next_pc, 32'h1004);
    chk("jalr_wr", rd_write, 1);
    chk("jalr_link", rd_data, 32'h204);

    // jal to a halfword target: fault at IALIGN=32, legal at IALIGN=16
    issue(C_JAL, -1, 32'h300, 0, 0, 32'h6, 1'b1);
    chk("jal32_misalign", misalign_err, 1);
    chk("jal32_no_jump", pc_j_valid, 0);
    chk("jal32_no_wr", rd_write, 0);
    chk("jal32_hold", next_pc, 32'h1004);
    chk("jal16_no_err", misalign_err16, 0);
    chk("jal16_jump", pc_j_valid16, 1);
    chk("jal16_next_pc", next_pc16, 32'h306);
    chk("jal16_link", rd_data16, 32'h304);
    @(negedge clk);
    chk("jal32_err_end", misalign_err, 0);

    // Multi-cycle ALU writeback
    issue(C_ADD, -1, 32'h20, 0, 0, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("alu_wait_busy", busy, 1);
      chk("alu_wait_ready", in_ready, 0);
      chk("alu_wait_wr", rd_write, 0);
      @(negedge clk);
    end
    alu_ready = 1'b1; alu_result = 32'hDEAD_BEEF;
    @(negedge clk);
    alu_ready = 1'b0; alu_result = 32'h0;
    chk("alu_wr", rd_write, 1);
    chk("alu_data", rd_data, 32'hDEAD_BEEF);
    chk("alu_idle", in_ready, 1);
    @(negedge clk);
    chk("alu_wr_end", rd_write, 0);
    chk("alu_data_hold", rd_data, 32'hDEAD_BEEF);

    // ALU already ready in RESOLVE
    alu_ready = 1'b1; alu_result = 32'h1234_5678;
    issue(C_ADD, -1, 32'h24, 0, 0, 0, 1'b1);
    alu_ready = 1'b0;
    chk("alu_fast_wr", rd_write, 1);
    chk("alu_fast_data", rd_data, 32'h1234_5678);
    chk("alu_fast_idle", in_ready, 1);

    // bne outranks beq but is not taken, so beq wins
    issue(C_BEQ, C_BNE, 32'h40, 32'h5, 32'h5, 32'hFFFF_FFF8, 1'b0);
    chk("beqbne_jump", pc_j_valid, 1);
    chk("beqbne_next_pc", next_pc, 32'h38);
    issue(C_BEQ, C_JAL, 32'h80, 32'h5, 32'h6, 32'h10, 1'b0);
    chk("prio_jal_next_pc", next_pc, 32'h90);
    issue(C_BEQ, -1, 32'h0, 32'h7, 32'h7, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_jump", pc_j_valid, 1);
    chk("wrap_next_pc", next_pc, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
